// File: rtl/multiplier_top_dft_if.sv
// Operand/product bundle for the Booth multiplier, including the DFT observation vectors.
interface multiplier_top_dft_if;
    logic [15:0] Multiplicant;
    logic [15:0] Multiplier;
    logic [31:0] result;
    logic [31:0] PP0, PP1, PP2, PP3, PP4, PP5, PP6, PP7;
    logic [31:0] Sum;
    logic [31:0] Carry;

    modport master (
        output Multiplicant, Multiplier,
        input  result, PP0, PP1, PP2, PP3, PP4, PP5, PP6, PP7, Sum, Carry
    );

    modport slave (
        input  Multiplicant, Multiplier,
        output result, PP0, PP1, PP2, PP3, PP4, PP5, PP6, PP7, Sum, Carry
    );
endinterface

// File: rtl/multiplier_top_dft.sv
// Signed 16x16 radix-4 Booth multiplier with a 3:2 carry-save tree, single output register
// stage, and the partial products plus final sum/carry vectors exposed for observation.
module multiplier_top_dft (
    input  logic                 clk,
    input  logic                 rst_n,
    multiplier_top_dft_if.slave  mul_if
);
    localparam int unsigned OP_W   = 16;
    localparam int unsigned PROD_W = 32;
    localparam int unsigned NUM_PP = 8;

    logic [OP_W:0]       b_ext;
    logic [PROD_W-1:0]   a_ext;
    logic [PROD_W-1:0]   pp_c [NUM_PP];
    logic [PROD_W-1:0]   s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;
    logic [PROD_W-1:0]   sum_c, carry_c, result_c;

    logic [PROD_W-1:0]   pp_q [NUM_PP];
    logic [PROD_W-1:0]   sum_q, carry_q, result_q;

    // Implicit B[-1] = 0 appended below the LSB so every digit sees a full triplet.
    assign b_ext = {mul_if.Multiplier, 1'b0};
    assign a_ext = {{(PROD_W-OP_W){mul_if.Multiplicant[OP_W-1]}}, mul_if.Multiplicant};

    for (genvar gi = 0; gi < NUM_PP; gi++) begin : g_booth
        logic [2:0]        trip;
        logic [PROD_W-1:0] mag;
        logic [PROD_W-1:0] sel;
        logic              neg;

        assign trip = b_ext[2*gi+2 -: 3];

        always_comb begin
            mag = '0;
            neg = 1'b0;
            case (trip)
                3'b001, 3'b010: mag = a_ext;
                3'b011:         mag = a_ext << 1;
                3'b100: begin
                    mag = a_ext << 1;
                    neg = 1'b1;
                end
                3'b101, 3'b110: begin
                    mag = a_ext;
                    neg = 1'b1;
                end
                default:        mag = '0;
            endcase
            sel = neg ? (~mag + PROD_W'(1)) : mag;
        end

        assign pp_c[gi] = sel << (2*gi);
    end

    // 3:2 compressor; carries out of the top bit are dropped by the shift.
    function automatic logic [2*PROD_W-1:0] csa(input logic [PROD_W-1:0] x,
                                                input logic [PROD_W-1:0] y,
                                                input logic [PROD_W-1:0] z);
        logic [PROD_W-1:0] s;
        logic [PROD_W-1:0] c;
        s = x ^ y ^ z;
        c = ((x & y) | (x & z) | (y & z)) << 1;
        return {c, s};
    endfunction

    // Wallace reduction 8 -> 6 -> 4 -> 3 -> 2.
    assign {c1, s1}           = csa(pp_c[0], pp_c[1], pp_c[2]);
    assign {c2, s2}           = csa(pp_c[3], pp_c[4], pp_c[5]);
    assign {c3, s3}           = csa(s1, c1, s2);
    assign {c4, s4}           = csa(c2, pp_c[6], pp_c[7]);
    assign {c5, s5}           = csa(s3, c3, s4);
    assign {carry_c, sum_c}   = csa(s5, c5, c4);

    assign result_c = sum_c + carry_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PP; i++) pp_q[i] <= '0;
            sum_q    <= '0;
            carry_q  <= '0;
            result_q <= '0;
        end else begin
            for (int i = 0; i < NUM_PP; i++) pp_q[i] <= pp_c[i];
            sum_q    <= sum_c;
            carry_q  <= carry_c;
            result_q <= result_c;
        end
    end

    assign mul_if.result = result_q;
    assign mul_if.Sum    = sum_q;
    assign mul_if.Carry  = carry_q;
    assign mul_if.PP0    = pp_q[0];
    assign mul_if.PP1    = pp_q[1];
    assign mul_if.PP2    = pp_q[2];
    assign mul_if.PP3    = pp_q[3];
    assign mul_if.PP4    = pp_q[4];
    assign mul_if.PP5    = pp_q[5];
    assign mul_if.PP6    = pp_q[6];
    assign mul_if.PP7    = pp_q[7];
endmodule

// File: tb/tb_multiplier_top_dft.sv
// Self-checking bench: directed corners plus random operands against an arithmetic Booth model.
module tb_multiplier_top_dft;
    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    multiplier_top_dft_if bus ();

    multiplier_top_dft dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .mul_if (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b);
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        return 32'(sa * sb);
    endfunction

    function automatic logic [31:0] ref_pp(input logic [15:0] a, input logic [15:0] b, input int i);
        int sa;
        int d;
        int lo;
        sa = $signed(a);
        lo = 0;
        if (i > 0) lo = int'(b[2*i-1]);
        d  = -2 * int'(b[2*i+1]) + int'(b[2*i]) + lo;
        return 32'(d * sa) << (2*i);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] obs_pp(input int i);
        case (i)
            0: return bus.PP0;
            1: return bus.PP1;
            2: return bus.PP2;
            3: return bus.PP3;
            4: return bus.PP4;
            5: return bus.PP5;
            6: return bus.PP6;
            default: return bus.PP7;
        endcase
    endfunction

    task automatic check_all(input string tag, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p = ref_prod(a, b);
        check({tag, "_result"}, bus.result, p);
        check({tag, "_sumcarry"}, bus.Sum + bus.Carry, p);
        for (int i = 0; i < 8; i++)
            check($sformatf("%s_pp%0d", tag, i), obs_pp(i), ref_pp(a, b, i));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_result"}, bus.result, 32'h0);
        check({tag, "_sum"}, bus.Sum, 32'h0);
        check({tag, "_carry"}, bus.Carry, 32'h0);
        for (int i = 0; i < 8; i++)
            check($sformatf("%s_pp%0d", tag, i), obs_pp(i), 32'h0);
    endtask

    // Apply operands, take one edge, sample just after it.
    task automatic step(input logic [15:0] a, input logic [15:0] b);
        bus.Multiplicant = a;
        bus.Multiplier   = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] ca [6];
        logic [15:0] cb [6];
        logic [31:0] ce [6];
        logic [15:0] ra;
        logic [15:0] rb;

        n_pass  = 0;
        n_total = 0;

        rst_n            = 1'b0;
        bus.Multiplicant = 16'h1234;
        bus.Multiplier   = 16'h5678;
        #3;
        check_zero("reset");

        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_first_product", bus.result, 32'h06260060);

        step(16'h0002, 16'h0003);
        check("obs_pp0", bus.PP0, 32'hFFFFFFFE);
        check("obs_pp1", bus.PP1, 32'h00000008);
        check("obs_pp2", bus.PP2, 32'h0);
        check("obs_pp7", bus.PP7, 32'h0);
        check("obs_sumcarry", bus.Sum + bus.Carry, 32'h00000006);
        check("obs_result", bus.result, 32'h00000006);
        check_all("obs", 16'h0002, 16'h0003);

        ca = '{16'h7FFF, 16'h8000, 16'h8000, 16'hFFFF, 16'h0003, 16'h0000};
        cb = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'hFFFF, 16'hFFFB, 16'h8000};
        ce = '{32'h3FFF0001, 32'h40000000, 32'hC0008000, 32'h00000001, 32'hFFFFFFF1, 32'h00000000};
        for (int k = 0; k < 6; k++) begin
            step(ca[k], cb[k]);
            check($sformatf("corner%0d", k), bus.result, ce[k]);
            check_all($sformatf("corner%0d", k), ca[k], cb[k]);
        end

        step(16'h0001, 16'h0001);
        check("b2b_0", bus.result, 32'h00000001);
        step(16'hFFFF, 16'h0002);
        check("b2b_1", bus.result, 32'hFFFFFFFE);
        step(16'h0100, 16'h0100);
        check("b2b_2", bus.result, 32'h00010000);

        for (int k = 0; k < 2000; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            step(ra, rb);
            check_all("rand", ra, rb);
        end

        // Mid-stream reset pulse between edges.
        ra = 16'h9ABC;
        rb = 16'h1357;
        step(ra, rb);
        check_all("pre_mid", ra, rb);
        bus.Multiplicant = 16'hC001;
        bus.Multiplier   = 16'h0FF3;
        #2 rst_n = 1'b0;
        #1;
        check_zero("mid_reset");
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_mid", 16'hC001, 16'h0FF3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
